stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised NUM_CH:1 streaming multiplexer with valid/ready handshake on every channel.
//  Successor to the combinational 4:1 select mux: it adds a registered output stage,
//  packet locking (in_last) and two modes, external select or round-robin arbitration.
//  Sits between per-channel producers and a single downstream consumer.
// PARAMETERS
//  NUM_CH  4  number of input channels (>=2)
//  DATA_W  8  payload width per channel
//  SEL_W   $clog2(NUM_CH)  width of sel/out_ch (derived, do not override)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  in_data    in   NUM_CH*DATA_W   channel i occupies bits [i*DATA_W +: DATA_W]
//  in_valid   in   NUM_CH          per-channel valid
//  in_last    in   NUM_CH          per-channel end-of-packet flag, qualified by in_valid
//  in_ready   out  NUM_CH          per-channel ready (combinational)
//  mode       in   1               0 = external select, 1 = round-robin
//  sel        in   SEL_W           channel index used when mode=0
//  out_data   out  DATA_W          registered payload
//  out_valid  out  1               registered valid
//  out_last   out  1               registered last flag
//  out_ch     out  SEL_W           source channel of the current out beat
//  out_ready  in   1               downstream ready
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr_ptr=0.
//   Asserting reset mid-packet drops the packet. No partial state survives reset.
//  A beat transfers on a port when valid && ready are both high at the clk edge.
//  Output stage can load when (!out_valid || out_ready). Call this ld.
//  Grant (cand channel, cand_ok flag), combinational:
//   IDLE, mode=1: first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
//    cand_ok = 1 if any in_valid is set.
//   IDLE, mode=0: cand=sel. cand_ok = (sel<NUM_CH) && in_valid[sel].
//    sel >= NUM_CH means no grant, ever.
//   BUSY: cand = locked gnt, with cand_ok=1. mode and sel are ignored until the packet ends.
//  in_ready[i] = cand_ok && (cand==i) && ld. All other in_ready bits are 0.
//  On an accepted beat from channel c:
//   - Register out_data/out_last from channel c. Set out_ch=c and out_valid=1.
//   - Latency is exactly 1 cycle from input accept to out_valid.
//   - in_last[c]=0: state goes to BUSY and gnt=c.
//   - in_last[c]=1: state goes to (or stays in) IDLE, and rr_ptr=(c+1) mod NUM_CH.
//   - rr_ptr updates in both modes.
//  out_valid && out_ready with no new accept: out_valid goes to 0. Data regs hold their values.
//  out_valid && !out_ready: out_* stay stable and all in_ready=0 (back-pressure).
//  Throughput is 1 beat/cycle with out_ready held high. There are no bubbles between packets.
//  A BUSY channel may drop in_valid mid-packet. The lock holds and no other channel is granted.
//  A mode/sel change while BUSY takes effect in the first IDLE cycle after the last beat.
//  Single-beat packets (in_last=1 on the first beat) never enter BUSY.
// TESTING
//  T1 reset: rst_n=0 mid-packet while out_ready=0 -> out_valid=0, out_ch=0, all in_ready=0
//   immediately. After release, ch0 gets the first rr grant.
//  T2 mode=0, sel=2, all valid, single beats, data 8'hA0..A3 -> out_data=8'hA2 every cycle,
//   out_ch=2, 1-cycle latency, in_ready=4'b0100.
//  T3 mode=1, all 4 channels valid, single beats, out_ready=1 -> out_ch sequence 0,1,2,3,0,...
//   at 1 beat/cycle.
//  T4 mode=1, ch1 sends a 3-beat packet while ch0 and ch3 are valid -> out_ch=1,1,1,3,0.
//   out_last=1 only on beat 3.
//  T5 back-pressure: out_ready=0 for 5 cycles while out_valid=1 -> out_* stable, in_ready=0.
//   Release -> next beat follows with no loss or duplicate.
//  T6 mode=0, sel=3'd... set sel=3 during a ch1 packet -> ch1 completes, then ch3 is granted.
//   With NUM_CH=3 and sel=3: no grant, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Stream mux bus: NUM_CH producer channels in, one consumer channel out.
//
// Handshake: a beat moves on a channel when valid and ready are both high at
// the rising clk edge. Valid must not wait for ready. While valid is high and
// ready is low, the producer holds its payload and last flag stable.
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  // Producer/consumer side: drives inputs and downstream ready.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );

  // Mux side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// NUM_CH:1 streaming mux with a registered output stage and packet locking.
// mode=0 takes the channel named by sel; mode=1 arbitrates round-robin.
// Once a packet's first beat is taken, the channel stays locked until in_last.
module stream_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_mux_rr_if.slave   bus,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic             dbg_busy,
  output logic [SEL_W-1:0] dbg_rr_ptr
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   gnt, gnt_nxt;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [SEL_W-1:0]   cand;
  logic               cand_ok;
  logic               ld;
  logic               accept;
  logic               cand_last;
  logic [DATA_W-1:0]  cand_data;
  int                 rr_idx;

  // Output register can take a new beat when empty or being drained.
  assign ld = !bus.out_valid || bus.out_ready;

  // Candidate selection: locked channel while BUSY, otherwise sel or rr scan.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    rr_idx  = 0;
    if (state == BUSY) begin
      cand    = gnt;
      cand_ok = 1'b1;
    end else if (mode) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rr_idx = int'(rr_ptr) + k;
        if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
        if (!cand_ok && bus.in_valid[rr_idx]) begin
          cand    = SEL_W'(rr_idx);
          cand_ok = 1'b1;
        end
      end
    end else begin
      cand = sel;
      // An out-of-range sel never grants anything.
      if (int'(sel) < NUM_CH) cand_ok = bus.in_valid[sel];
    end
  end

  // Ready goes only to the candidate, and only when the output can load.
  // Gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_ready[i] = rst_n && cand_ok && ld && (cand == SEL_W'(i));
    end
  end

  assign accept    = |(bus.in_valid & bus.in_ready);
  assign cand_data = bus.in_data[int'(cand)*DATA_W +: DATA_W];
  assign cand_last = bus.in_last[cand];

  // Next-state: lock on a non-last beat, release and advance rr_ptr on last.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    if (accept) begin
      if (cand_last) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = (int'(cand) == NUM_CH - 1) ? '0 : cand + SEL_W'(1);
      end else begin
        state_nxt = BUSY;
        gnt_nxt   = cand;
      end
    end
  end

  // State, lock and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Output stage: load on accept, clear valid when drained, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_ch    <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= cand_data;
      bus.out_last  <= cand_last;
      bus.out_ch    <= cand;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  assign dbg_busy   = (state == BUSY);
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main
// scenarios and a 3-channel instance for the out-of-range select case.
module tb_stream_mux_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode4, mode3;
  logic [1:0] sel4, sel3;
  logic       busy4, busy3;
  logic [1:0] rr4, rr3;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.NUM_CH(4), .DATA_W(8)) bus4 ();
  stream_mux_rr_if #(.NUM_CH(3), .DATA_W(8)) bus3 ();

  stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .mode(mode4), .sel(sel4),
    .dbg_busy(busy4), .dbg_rr_ptr(rr4)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .mode(mode3), .sel(sel3),
    .dbg_busy(busy3), .dbg_rr_ptr(rr3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus4.in_valid  = '0;
    bus4.in_last   = '0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b1;
    mode4          = 1'b1;
    sel4           = '0;
    bus3.in_valid  = '0;
    bus3.in_last   = '0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b1;
    mode3          = 1'b0;
    sel3           = '0;
  endtask

  task automatic test_reset();
    set_idle();
    do_reset();
    mode4          = 1'b1;
    bus4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.in_valid  = 4'b0010;
    bus4.in_last   = 4'b0000;
    bus4.out_ready = 1'b0;
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, busy4} !== {1'b1, 2'd1, 1'b1}) begin
      $display("FAIL reset_pre_beat: got v/ch/busy=%b/%0d/%b want 1/1/1", bus4.out_valid, bus4.out_ch, busy4);
      n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last} !== 12'h000) begin
      $display("FAIL reset_out: got v=%b ch=%0d d=%h l=%b want all 0", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last);
      n_fail++;
    end
    n_tests++;
    if ({bus4.in_ready, busy4, rr4} !== 7'b0) begin
      $display("FAIL reset_ready_state: got rdy=%b busy=%b rr=%0d want 0000/0/0", bus4.in_ready, busy4, rr4);
      n_fail++;
    end
    rst_n          = 1'b1;
    bus4.in_valid  = 4'b1111;
    bus4.in_last   = 4'b1111;
    bus4.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b0001) begin
      $display("FAIL reset_first_grant: got rdy=%b want 0001", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== {1'b1, 2'd0, 8'h10}) begin
      $display("FAIL reset_first_beat: got v=%b ch=%0d d=%h want 1/0/10", bus4.out_valid, bus4.out_ch, bus4.out_data);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  task automatic test_sel();
    set_idle();
    do_reset();
    mode4         = 1'b0;
    sel4          = 2'd2;
    bus4.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus4.in_valid = 4'b1111;
    bus4.in_last  = 4'b1111;
    #1;
    n_tests++;
    if ({bus4.in_ready, bus4.out_valid} !== {4'b0100, 1'b0}) begin
      $display("FAIL sel_latency: got rdy=%b v=%b want 0100/0", bus4.in_ready, bus4.out_valid);
      n_fail++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.in_ready} !== {1'b1, 2'd2, 8'hA2, 4'b0100}) begin
        $display("FAIL sel_beat%0d: got v=%b ch=%0d d=%h rdy=%b want 1/2/a2/0100", k, bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.in_ready);
        n_fail++;
      end
    end
    set_idle();
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] e_ch;
    logic [7:0] e_d;
    set_idle();
    do_reset();
    mode4         = 1'b1;
    bus4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.in_valid = 4'b1111;
    bus4.in_last  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      e_ch = 2'(k % 4);
      e_d  = 8'h10 + 8'(k % 4);
      n_tests++;
      if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== {1'b1, e_ch, e_d}) begin
        $display("FAIL rr_beat%0d: got v=%b ch=%0d d=%h want 1/%0d/%h", k, bus4.out_valid, bus4.out_ch, bus4.out_data, e_ch, e_d);
        n_fail++;
      end
    end
    set_idle();
    step();
  endtask

  task automatic test_packet_lock();
    set_idle();
    do_reset();
    mode4         = 1'b1;
    bus4.in_data  = {8'hD3, 8'h00, 8'hB0, 8'hC0};
    bus4.in_valid = 4'b0001;
    bus4.in_last  = 4'b0001;
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== {1'b1, 2'd0, 8'hC0}) begin
      $display("FAIL lock_warmup: got v=%b ch=%0d d=%h want 1/0/c0", bus4.out_valid, bus4.out_ch, bus4.out_data);
      n_fail++;
    end
    bus4.in_valid = 4'b1011;
    bus4.in_last  = 4'b1001;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b0010) begin
      $display("FAIL lock_grant: got rdy=%b want 0010", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last, busy4} !== {1'b1, 2'd1, 8'hB0, 1'b0, 1'b1}) begin
      $display("FAIL lock_beat1: got v=%b ch=%0d d=%h l=%b busy=%b want 1/1/b0/0/1", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last, busy4);
      n_fail++;
    end
    bus4.in_valid = 4'b1001;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b0010) begin
      $display("FAIL lock_hold: got rdy=%b want 0010", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, busy4} !== 2'b01) begin
      $display("FAIL lock_bubble: got v=%b busy=%b want 0/1", bus4.out_valid, busy4);
      n_fail++;
    end
    bus4.in_valid      = 4'b1011;
    bus4.in_data[15:8] = 8'hB1;
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last} !== {1'b1, 2'd1, 8'hB1, 1'b0}) begin
      $display("FAIL lock_beat2: got v=%b ch=%0d d=%h l=%b want 1/1/b1/0", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last);
      n_fail++;
    end
    bus4.in_data[15:8] = 8'hB2;
    bus4.in_last       = 4'b1011;
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last, busy4, rr4} !== {1'b1, 2'd1, 8'hB2, 1'b1, 1'b0, 2'd2}) begin
      $display("FAIL lock_beat3: got v=%b ch=%0d d=%h l=%b busy=%b rr=%0d want 1/1/b2/1/0/2", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last, busy4, rr4);
      n_fail++;
    end
    bus4.in_valid = 4'b1001;
    bus4.in_last  = 4'b1001;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b1000) begin
      $display("FAIL lock_next_grant: got rdy=%b want 1000", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last} !== {1'b1, 2'd3, 8'hD3, 1'b1}) begin
      $display("FAIL lock_after_ch3: got v=%b ch=%0d d=%h l=%b want 1/3/d3/1", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last} !== {1'b1, 2'd0, 8'hC0, 1'b1}) begin
      $display("FAIL lock_after_ch0: got v=%b ch=%0d d=%h l=%b want 1/0/c0/1", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  task automatic test_back_pressure();
    set_idle();
    do_reset();
    mode4         = 1'b1;
    bus4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.in_valid = 4'b1111;
    bus4.in_last  = 4'b1111;
    step();
    bus4.out_ready = 1'b0;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b0000) begin
      $display("FAIL bp_ready_drop: got rdy=%b want 0000", bus4.in_ready);
      n_fail++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.in_ready} !== {1'b1, 2'd0, 8'h10, 4'b0000}) begin
        $display("FAIL bp_hold%0d: got v=%b ch=%0d d=%h rdy=%b want 1/0/10/0000", k, bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.in_ready);
        n_fail++;
      end
    end
    bus4.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b0010) begin
      $display("FAIL bp_release_grant: got rdy=%b want 0010", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== {1'b1, 2'd1, 8'h11}) begin
      $display("FAIL bp_next1: got v=%b ch=%0d d=%h want 1/1/11", bus4.out_valid, bus4.out_ch, bus4.out_data);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== {1'b1, 2'd2, 8'h12}) begin
      $display("FAIL bp_next2: got v=%b ch=%0d d=%h want 1/2/12", bus4.out_valid, bus4.out_ch, bus4.out_data);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  task automatic test_sel_change();
    set_idle();
    do_reset();
    mode4         = 1'b0;
    sel4          = 2'd1;
    bus4.in_data  = {8'hD3, 8'h00, 8'hB0, 8'h00};
    bus4.in_valid = 4'b1010;
    bus4.in_last  = 4'b1000;
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, busy4} !== {1'b1, 2'd1, 8'hB0, 1'b1}) begin
      $display("FAIL selchg_beat1: got v=%b ch=%0d d=%h busy=%b want 1/1/b0/1", bus4.out_valid, bus4.out_ch, bus4.out_data, busy4);
      n_fail++;
    end
    sel4               = 2'd3;
    bus4.in_data[15:8] = 8'hB1;
    bus4.in_last       = 4'b1010;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b0010) begin
      $display("FAIL selchg_locked: got rdy=%b want 0010", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last} !== {1'b1, 2'd1, 8'hB1, 1'b1}) begin
      $display("FAIL selchg_beat2: got v=%b ch=%0d d=%h l=%b want 1/1/b1/1", bus4.out_valid, bus4.out_ch, bus4.out_data, bus4.out_last);
      n_fail++;
    end
    bus4.in_valid = 4'b1000;
    #1;
    n_tests++;
    if (bus4.in_ready !== 4'b1000) begin
      $display("FAIL selchg_new_grant: got rdy=%b want 1000", bus4.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== {1'b1, 2'd3, 8'hD3}) begin
      $display("FAIL selchg_ch3: got v=%b ch=%0d d=%h want 1/3/d3", bus4.out_valid, bus4.out_ch, bus4.out_data);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  task automatic test_no_grant();
    set_idle();
    do_reset();
    mode3         = 1'b0;
    sel3          = 2'd3;
    bus3.in_data  = {8'h52, 8'h51, 8'h50};
    bus3.in_valid = 3'b111;
    bus3.in_last  = 3'b111;
    #1;
    n_tests++;
    if (bus3.in_ready !== 3'b000) begin
      $display("FAIL nogrant_ready: got rdy=%b want 000", bus3.in_ready);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (bus3.out_valid !== 1'b0) begin
        $display("FAIL nogrant_valid%0d: got v=%b want 0", k, bus3.out_valid);
        n_fail++;
      end
    end
    sel3 = 2'd2;
    #1;
    n_tests++;
    if (bus3.in_ready !== 3'b100) begin
      $display("FAIL nogrant_top_sel: got rdy=%b want 100", bus3.in_ready);
      n_fail++;
    end
    step();
    n_tests++;
    if ({bus3.out_valid, bus3.out_ch, bus3.out_data} !== {1'b1, 2'd2, 8'h52}) begin
      $display("FAIL nogrant_top_beat: got v=%b ch=%0d d=%h want 1/2/52", bus3.out_valid, bus3.out_ch, bus3.out_data);
      n_fail++;
    end
    set_idle();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_sel();
    test_round_robin();
    test_packet_lock();
    test_back_pressure();
    test_sel_change();
    test_no_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
